controlador_ula: RTL and testbench

- Sequential command front-end and initiator for the 8-bit ALU.
- Accepts operation requests {Sel_Op, A, B} on a valid/ready handshake and rejects illegal opcodes and division by zero before issue.
- Drives registered operands onto the ALU inputs and waits a fixed settle time for the combinational datapath.
- Captures Resultado and the comparator flags, then returns them on a valid/ready response channel. Sits between the instruction sequencer and the ALU.

---
 rtl/controlador_ula_pkg.sv | 31 +++
 rtl/controlador_ula_valida_op.sv | 21 ++
 rtl/controlador_ula.sv | 130 +++++++++++++
 tb/tb_controlador_ula.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_ula_pkg.sv
// Shared opcode, error-code and state definitions for the ALU command controller.
// Also used by the ALU top and by the instruction sequencer.
package controlador_ula_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'b00,
      ESPERA   = 2'b01,
      RESPONDE = 2'b10
   } estado_t;

   localparam logic [3:0] OP_SOMA  = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_MULT  = 4'b0010;
   localparam logic [3:0] OP_QUOC  = 4'b0011;
   localparam logic [3:0] OP_RESTO = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0110;
   localparam logic [3:0] OP_OR    = 4'b0111;
   localparam logic [3:0] OP_XOR   = 4'b1000;
   localparam logic [3:0] OP_NAND  = 4'b1001;
   localparam logic [3:0] OP_NOR   = 4'b1010;
   localparam logic [3:0] OP_NOT   = 4'b1011;

   localparam logic [1:0] ERRO_OK     = 2'b00;
   localparam logic [1:0] ERRO_OPCODE = 2'b01;
   localparam logic [1:0] ERRO_DIV0   = 2'b10;

   function automatic logic [7:0] incr_sat8(input logic [7:0] valor);
      return (valor == 8'hFF) ? valor : valor + 8'd1;
   endfunction

endpackage

// File: rtl/controlador_ula_valida_op.sv
// Combinational command checker: classifies an opcode/operand-B pair as ok,
// illegal opcode or divide by zero.
module controlador_ula_valida_op
   import controlador_ula_pkg::*;
(
   input  logic [3:0] Sel_Op,
   input  logic [7:0] B,
   output logic [1:0] Codigo
);

   always_comb begin
      Codigo = ERRO_OK;
      // 0101 is a hole in the encoding; everything above OP_NOT is unassigned
      if ((Sel_Op == 4'b0101) || (Sel_Op > OP_NOT)) begin
         Codigo = ERRO_OPCODE;
      end else if (((Sel_Op == OP_QUOC) || (Sel_Op == OP_RESTO)) && (B == 8'h00)) begin
         Codigo = ERRO_DIV0;
      end
   end

endmodule

// File: rtl/controlador_ula.sv
// Command front-end for the 8-bit ALU: accepts a request, holds the ALU inputs
// for a fixed settle time, captures result and flags, and returns a response.
module controlador_ula
   import controlador_ula_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CONT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Cmd_Valid,
   output logic              Cmd_Ready,
   input  logic [3:0]        Cmd_Sel_Op,
   input  logic [7:0]        Cmd_A,
   input  logic [7:0]        Cmd_B,
   output logic [7:0]        Ula_A,
   output logic [7:0]        Ula_B,
   output logic [3:0]        Ula_Sel_Op,
   input  logic [15:0]       Ula_Resultado,
   input  logic              Ula_Maior,
   input  logic              Ula_Menor,
   input  logic              Ula_Igual,
   output logic              Rsp_Valid,
   input  logic              Rsp_Ready,
   output logic [15:0]       Rsp_Resultado,
   output logic              Rsp_Maior,
   output logic              Rsp_Menor,
   output logic              Rsp_Igual,
   output logic [1:0]        Rsp_Codigo_Erro,
   output logic [CONT_W-1:0] Num_Ops,
   output logic [7:0]        Num_Erros
);

   localparam logic [3:0] CONT_INI = 4'(SETTLE_CYCLES - 1);

   estado_t    estado, prox_estado;
   logic [3:0] cont_espera;
   logic [1:0] cod_cmd;
   logic [1:0] cod_pend;

   controlador_ula_valida_op u_valida (
      .Sel_Op (Cmd_Sel_Op),
      .B      (Cmd_B),
      .Codigo (cod_cmd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox_estado;
      end
   end

   always_comb begin
      prox_estado = estado;
      Cmd_Ready   = 1'b0;
      Rsp_Valid   = 1'b0;
      case (estado)
         OCIOSO: begin
            Cmd_Ready = 1'b1;
            if (Cmd_Valid) prox_estado = ESPERA;
         end
         ESPERA: begin
            if (cont_espera == 4'd0) prox_estado = RESPONDE;
         end
         RESPONDE: begin
            Rsp_Valid = 1'b1;
            if (Rsp_Ready) prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_espera     <= 4'd0;
         cod_pend        <= ERRO_OK;
         Ula_A           <= 8'd0;
         Ula_B           <= 8'd0;
         Ula_Sel_Op      <= 4'd0;
         Rsp_Resultado   <= 16'd0;
         Rsp_Maior       <= 1'b0;
         Rsp_Menor       <= 1'b0;
         Rsp_Igual       <= 1'b0;
         Rsp_Codigo_Erro <= ERRO_OK;
         Num_Ops         <= '0;
         Num_Erros       <= 8'd0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (Cmd_Valid) begin
                  Ula_A      <= Cmd_A;
                  Ula_B      <= Cmd_B;
                  Ula_Sel_Op <= Cmd_Sel_Op;
                  cod_pend   <= cod_cmd;
                  // rejected commands skip the settle time and answer one edge later
                  cont_espera <= (cod_cmd == ERRO_OK) ? CONT_INI : 4'd0;
               end
            end
            ESPERA: begin
               if (cont_espera == 4'd0) begin
                  Rsp_Codigo_Erro <= cod_pend;
                  if (cod_pend == ERRO_OK) begin
                     Rsp_Resultado <= Ula_Resultado;
                     Rsp_Maior     <= Ula_Maior;
                     Rsp_Menor     <= Ula_Menor;
                     Rsp_Igual     <= Ula_Igual;
                  end else begin
                     Rsp_Resultado <= 16'd0;
                     Rsp_Maior     <= 1'b0;
                     Rsp_Menor     <= 1'b0;
                     Rsp_Igual     <= 1'b0;
                  end
               end else begin
                  cont_espera <= cont_espera - 4'd1;
               end
            end
            RESPONDE: begin
               if (Rsp_Ready) begin
                  Num_Ops <= Num_Ops + CONT_W'(1);
                  if (Rsp_Codigo_Erro != ERRO_OK) Num_Erros <= incr_sat8(Num_Erros);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_ula.sv
// Bench for controlador_ula: directed scenarios plus randomized commands
// checked against a behavioural model of the ALU and of the controller rules.
module tb_controlador_ula;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Cmd_Valid, Cmd_Ready;
   logic [3:0]  Cmd_Sel_Op;
   logic [7:0]  Cmd_A, Cmd_B;
   logic [7:0]  Ula_A, Ula_B;
   logic [3:0]  Ula_Sel_Op;
   logic [15:0] Ula_Resultado;
   logic        Ula_Maior, Ula_Menor, Ula_Igual;
   logic        Rsp_Valid, Rsp_Ready;
   logic [15:0] Rsp_Resultado;
   logic        Rsp_Maior, Rsp_Menor, Rsp_Igual;
   logic [1:0]  Rsp_Codigo_Erro;
   logic [15:0] Num_Ops;
   logic [7:0]  Num_Erros;

   // second instance with a longer settle time; its ALU inputs are driven directly
   logic        cmd_valid4, cmd_ready4;
   logic [3:0]  cmd_sel4;
   logic [7:0]  cmd_a4, cmd_b4;
   logic [7:0]  ula_a4, ula_b4;
   logic [3:0]  ula_sel4;
   logic [15:0] ula_res4;
   logic        ula_maior4, ula_menor4, ula_igual4;
   logic        rsp_valid4, rsp_ready4;
   logic [15:0] rsp_res4;
   logic        rsp_maior4, rsp_menor4, rsp_igual4;
   logic [1:0]  rsp_cod4;
   logic [15:0] num_ops4;
   logic [7:0]  num_erros4;

   int tests = 0;
   int fails = 0;
   int exp_ops = 0;
   int exp_erros = 0;

   always #5 clk = ~clk;

   function automatic logic [18:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
      logic [15:0] x, y, r;
      x = {8'h00, a};
      y = {8'h00, b};
      case (sel)
         4'd0:    r = x + y;
         4'd1:    r = x - y;
         4'd2:    r = x * y;
         4'd3:    r = (b != 8'd0) ? x / y : 16'hFFFF;
         4'd4:    r = (b != 8'd0) ? x % y : x;
         4'd6:    r = x & y;
         4'd7:    r = x | y;
         4'd8:    r = x ^ y;
         4'd9:    r = {8'h00, ~(a & b)};
         4'd10:   r = {8'h00, ~(a | b)};
         4'd11:   r = {8'h00, ~a};
         default: r = 16'hDEAD;
      endcase
      return {a > b, a < b, a == b, r};
   endfunction

   // {codigo[1:0], maior, menor, igual, resultado[15:0]}
   function automatic logic [20:0] modelo(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
      if (sel == 4'd5 || sel >= 4'd12) return {2'b01, 19'd0};
      if ((sel == 4'd3 || sel == 4'd4) && b == 8'd0) return {2'b10, 19'd0};
      return {2'b00, alu(a, b, sel)};
   endfunction

   logic [18:0] alu0;
   assign alu0 = alu(Ula_A, Ula_B, Ula_Sel_Op);
   assign Ula_Resultado = alu0[15:0];
   assign {Ula_Maior, Ula_Menor, Ula_Igual} = alu0[18:16];

   controlador_ula #(.SETTLE_CYCLES(2), .CONT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Sel_Op(Cmd_Sel_Op),
      .Cmd_A(Cmd_A), .Cmd_B(Cmd_B),
      .Ula_A(Ula_A), .Ula_B(Ula_B), .Ula_Sel_Op(Ula_Sel_Op),
      .Ula_Resultado(Ula_Resultado), .Ula_Maior(Ula_Maior), .Ula_Menor(Ula_Menor), .Ula_Igual(Ula_Igual),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Resultado(Rsp_Resultado),
      .Rsp_Maior(Rsp_Maior), .Rsp_Menor(Rsp_Menor), .Rsp_Igual(Rsp_Igual),
      .Rsp_Codigo_Erro(Rsp_Codigo_Erro), .Num_Ops(Num_Ops), .Num_Erros(Num_Erros)
   );

   controlador_ula #(.SETTLE_CYCLES(4), .CONT_W(16)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .Cmd_Valid(cmd_valid4), .Cmd_Ready(cmd_ready4), .Cmd_Sel_Op(cmd_sel4),
      .Cmd_A(cmd_a4), .Cmd_B(cmd_b4),
      .Ula_A(ula_a4), .Ula_B(ula_b4), .Ula_Sel_Op(ula_sel4),
      .Ula_Resultado(ula_res4), .Ula_Maior(ula_maior4), .Ula_Menor(ula_menor4), .Ula_Igual(ula_igual4),
      .Rsp_Valid(rsp_valid4), .Rsp_Ready(rsp_ready4), .Rsp_Resultado(rsp_res4),
      .Rsp_Maior(rsp_maior4), .Rsp_Menor(rsp_menor4), .Rsp_Igual(rsp_igual4),
      .Rsp_Codigo_Erro(rsp_cod4), .Num_Ops(num_ops4), .Num_Erros(num_erros4)
   );

   // Issues one command on the main instance, scrambles the command inputs while
   // busy, then completes the handshake after rdy_delay cycles of backpressure.
   task automatic do_cmd(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input int rdy_delay, output int lat, output logic [15:0] res,
                         output logic [2:0] flg, output logic [1:0] cod);
      Cmd_Sel_Op = sel;
      Cmd_A      = a;
      Cmd_B      = b;
      Cmd_Valid  = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (Rsp_Valid !== 1'b1 && lat < 40) begin
         Cmd_Valid  = 1'($urandom_range(0, 1));
         Cmd_A      = 8'($urandom);
         Cmd_B      = 8'($urandom);
         Cmd_Sel_Op = 4'($urandom);
         Rsp_Ready  = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      res = Rsp_Resultado;
      flg = {Rsp_Maior, Rsp_Menor, Rsp_Igual};
      cod = Rsp_Codigo_Erro;
      Rsp_Ready = 1'b0;
      Cmd_Valid = 1'b0;
      repeat (rdy_delay) begin
         @(posedge clk); #1;
      end
      Rsp_Ready = 1'b1;
      @(posedge clk); #1;
      Rsp_Ready = 1'b0;
   endtask

   task automatic model_done(input logic [1:0] cod);
      exp_ops = (exp_ops + 1) % 65536;
      if (cod != 2'b00 && exp_erros < 255) exp_erros++;
   endtask

   task automatic test_reset();
      int lat, vistos;
      logic [15:0] res;
      logic [2:0] flg;
      logic [1:0] cod;
      do_cmd(4'd2, 8'hC3, 8'h7E, 0, lat, res, flg, cod);
      model_done(cod);
      tests++;
      if (Num_Ops !== 16'd1) begin
         fails++; $display("FAIL pre_reset_ops got %0d want 1", Num_Ops);
      end
      Cmd_Sel_Op = 4'd2; Cmd_A = 8'hFF; Cmd_B = 8'hFF; Cmd_Valid = 1'b1;
      @(posedge clk); #1;
      Cmd_Valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (Cmd_Ready !== 1'b0 || Rsp_Valid !== 1'b0) begin
         fails++; $display("FAIL reset_busy ready=%b valid=%b want 0 0", Cmd_Ready, Rsp_Valid);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({Cmd_Ready, Rsp_Valid, Ula_A, Ula_B, Ula_Sel_Op, Rsp_Resultado, Rsp_Maior, Rsp_Menor,
           Rsp_Igual, Rsp_Codigo_Erro, Num_Ops, Num_Erros} !== {1'b1, 1'b0, 65'd0}) begin
         fails++;
         $display("FAIL reset_async got rdy=%b vld=%b ua=%h ub=%h us=%h res=%h f=%b%b%b cod=%b ops=%0d err=%0d want rdy=1 rest 0",
                  Cmd_Ready, Rsp_Valid, Ula_A, Ula_B, Ula_Sel_Op, Rsp_Resultado, Rsp_Maior, Rsp_Menor,
                  Rsp_Igual, Rsp_Codigo_Erro, Num_Ops, Num_Erros);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ops = 0; exp_erros = 0;
      vistos = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (Rsp_Valid === 1'b1) vistos++;
      end
      tests++;
      if (vistos != 0 || Num_Ops !== 16'd0 || Cmd_Ready !== 1'b1) begin
         fails++; $display("FAIL reset_abandon valid_cycles=%0d ops=%0d ready=%b want 0 0 1", vistos, Num_Ops, Cmd_Ready);
      end
   endtask

   task automatic test_soma();
      int lat;
      logic [15:0] res;
      logic [2:0] flg;
      logic [1:0] cod;
      do_cmd(4'b0000, 8'h05, 8'h03, 0, lat, res, flg, cod);
      model_done(2'b00);
      tests++;
      if (lat != 2) begin fails++; $display("FAIL soma_latency got %0d want 2", lat); end
      tests++;
      if ({res, flg, cod} !== {16'h0008, 3'b100, 2'b00}) begin
         fails++; $display("FAIL soma_rsp got res=%h flg=%b cod=%b want 0008 100 00", res, flg, cod);
      end
      tests++;
      if (Num_Ops !== 16'd1) begin fails++; $display("FAIL soma_num_ops got %0d want 1", Num_Ops); end
   endtask

   task automatic test_div0();
      int lat;
      logic [15:0] res;
      logic [2:0] flg;
      logic [1:0] cod;
      do_cmd(4'b0011, 8'h40, 8'h00, 1, lat, res, flg, cod);
      model_done(2'b10);
      tests++;
      if (lat != 1) begin fails++; $display("FAIL div0_latency got %0d want 1", lat); end
      tests++;
      if ({res, flg, cod} !== {16'h0000, 3'b000, 2'b10}) begin
         fails++; $display("FAIL div0_rsp got res=%h flg=%b cod=%b want 0000 000 10", res, flg, cod);
      end
      tests++;
      if (Num_Erros !== 8'd1 || Num_Ops !== 16'd2) begin
         fails++; $display("FAIL div0_counts got err=%0d ops=%0d want 1 2", Num_Erros, Num_Ops);
      end
      tests++;
      if ({Ula_A, Ula_B, Ula_Sel_Op} !== {8'h40, 8'h00, 4'b0011}) begin
         fails++; $display("FAIL div0_ula_load got %h %h %h want 40 00 3", Ula_A, Ula_B, Ula_Sel_Op);
      end
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] res;
      logic [2:0] flg;
      logic [1:0] cod;
      logic [3:0] sel;
      logic [7:0] a, b;
      logic [20:0] e;
      for (int i = 0; i < 40; i++) begin
         sel = 4'($urandom);
         a   = 8'($urandom);
         b   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         e   = modelo(sel, a, b);
         do_cmd(sel, a, b, $urandom_range(0, 2), lat, res, flg, cod);
         model_done(e[20:19]);
         tests++;
         if (lat != ((e[20:19] == 2'b00) ? 2 : 1)) begin
            fails++; $display("FAIL rand_latency sel=%h got %0d want %0d", sel, lat, (e[20:19] == 2'b00) ? 2 : 1);
         end
         tests++;
         if ({cod, flg, res} !== e) begin
            fails++; $display("FAIL rand_rsp sel=%h a=%h b=%h got %h want %h", sel, a, b, {cod, flg, res}, e);
         end
         tests++;
         if (Num_Ops !== 16'(exp_ops) || Num_Erros !== 8'(exp_erros)) begin
            fails++; $display("FAIL rand_counts got ops=%0d err=%0d want %0d %0d", Num_Ops, Num_Erros, exp_ops, exp_erros);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [7:0] a, b, na, nb;
      logic [20:0] e, ne;
      a = 8'($urandom); b = 8'($urandom);
      e = modelo(4'd2, a, b);
      Cmd_Sel_Op = 4'd2; Cmd_A = a; Cmd_B = b; Cmd_Valid = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (Rsp_Valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      for (int i = 0; i < 5; i++) begin
         Cmd_A = 8'($urandom); Cmd_B = 8'($urandom); Cmd_Sel_Op = 4'd0;
         @(posedge clk); #1;
         tests++;
         if ({Rsp_Valid, Cmd_Ready, Rsp_Codigo_Erro, Rsp_Maior, Rsp_Menor, Rsp_Igual, Rsp_Resultado,
              Ula_A, Ula_B, Ula_Sel_Op} !== {1'b1, 1'b0, e, a, b, 4'd2}) begin
            fails++;
            $display("FAIL backpressure_hold cyc=%0d got vld=%b rdy=%b rsp=%h ula=%h/%h/%h want 1 0 %h %h/%h/2",
                     i, Rsp_Valid, Cmd_Ready, {Rsp_Codigo_Erro, Rsp_Maior, Rsp_Menor, Rsp_Igual, Rsp_Resultado},
                     Ula_A, Ula_B, Ula_Sel_Op, e, a, b);
         end
      end
      na = 8'($urandom); nb = 8'($urandom);
      ne = modelo(4'd0, na, nb);
      Cmd_A = na; Cmd_B = nb; Cmd_Sel_Op = 4'd0;
      Rsp_Ready = 1'b1;
      @(posedge clk); #1;
      Rsp_Ready = 1'b0;
      model_done(2'b00);
      tests++;
      if ({Cmd_Ready, Rsp_Valid, Rsp_Resultado} !== {1'b1, 1'b0, e[15:0]} || Num_Ops !== 16'(exp_ops)) begin
         fails++; $display("FAIL backpressure_release got rdy=%b vld=%b res=%h ops=%0d want 1 0 %h %0d",
                           Cmd_Ready, Rsp_Valid, Rsp_Resultado, Num_Ops, e[15:0], exp_ops);
      end
      @(posedge clk); #1;
      Cmd_Valid = 1'b0;
      tests++;
      if ({Cmd_Ready, Ula_A, Ula_B} !== {1'b0, na, nb}) begin
         fails++; $display("FAIL backpressure_accept got rdy=%b ua=%h ub=%h want 0 %h %h", Cmd_Ready, Ula_A, Ula_B, na, nb);
      end
      n = 0;
      while (Rsp_Valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      tests++;
      if ({Rsp_Valid, Rsp_Codigo_Erro, Rsp_Maior, Rsp_Menor, Rsp_Igual, Rsp_Resultado} !== {1'b1, ne}) begin
         fails++; $display("FAIL backpressure_next got vld=%b rsp=%h want 1 %h", Rsp_Valid,
                           {Rsp_Codigo_Erro, Rsp_Maior, Rsp_Menor, Rsp_Igual, Rsp_Resultado}, ne);
      end
      Rsp_Ready = 1'b1;
      @(posedge clk); #1;
      Rsp_Ready = 1'b0;
      model_done(2'b00);
   endtask

   task automatic test_illegal();
      int lat;
      logic [15:0] res;
      logic [2:0] flg;
      logic [1:0] cod;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ops = 0; exp_erros = 0;
      for (int i = 0; i < 300; i++) begin
         do_cmd(4'b0101, 8'($urandom), 8'($urandom), 0, lat, res, flg, cod);
         model_done(2'b01);
         tests++;
         if ({cod, flg, res} !== {2'b01, 19'd0} || lat != 1) begin
            fails++; $display("FAIL illegal_rsp iter=%0d got cod=%b flg=%b res=%h lat=%0d want 01 000 0000 1", i, cod, flg, res, lat);
         end
         tests++;
         if (Num_Erros !== 8'(exp_erros)) begin
            fails++; $display("FAIL illegal_erros iter=%0d got %0d want %0d", i, Num_Erros, exp_erros);
         end
      end
      tests++;
      if (Num_Erros !== 8'd255 || Num_Ops !== 16'd300) begin
         fails++; $display("FAIL illegal_saturate got err=%0d ops=%0d want 255 300", Num_Erros, Num_Ops);
      end
   endtask

   task automatic test_capture();
      cmd_sel4 = 4'd0; cmd_a4 = 8'h12; cmd_b4 = 8'h34; cmd_valid4 = 1'b1;
      ula_res4 = 16'h1111; {ula_maior4, ula_menor4, ula_igual4} = 3'b001;
      @(posedge clk); #1;
      cmd_valid4 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      tests++;
      if (rsp_valid4 !== 1'b0) begin fails++; $display("FAIL capture_early got valid=%b want 0", rsp_valid4); end
      ula_res4 = 16'hBEEF; {ula_maior4, ula_menor4, ula_igual4} = 3'b010;
      @(posedge clk); #1;
      ula_res4 = 16'h2222; {ula_maior4, ula_menor4, ula_igual4} = 3'b100;
      tests++;
      if ({rsp_valid4, rsp_res4, rsp_maior4, rsp_menor4, rsp_igual4, rsp_cod4} !== {1'b1, 16'hBEEF, 3'b010, 2'b00}) begin
         fails++; $display("FAIL capture_value got vld=%b res=%h f=%b%b%b cod=%b want 1 beef 010 00",
                           rsp_valid4, rsp_res4, rsp_maior4, rsp_menor4, rsp_igual4, rsp_cod4);
      end
      @(posedge clk); #1;
      rsp_ready4 = 1'b1;
      @(posedge clk); #1;
      rsp_ready4 = 1'b0;
      tests++;
      if ({rsp_valid4, cmd_ready4, rsp_res4, rsp_maior4, rsp_menor4, rsp_igual4, num_ops4, ula_a4} !==
          {1'b0, 1'b1, 16'hBEEF, 3'b010, 16'd1, 8'h12}) begin
         fails++; $display("FAIL capture_hold got vld=%b rdy=%b res=%h f=%b%b%b ops=%0d ua=%h want 0 1 beef 010 1 12",
                           rsp_valid4, cmd_ready4, rsp_res4, rsp_maior4, rsp_menor4, rsp_igual4, num_ops4, ula_a4);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      Cmd_Valid = 1'b0; Cmd_Sel_Op = 4'd0; Cmd_A = 8'd0; Cmd_B = 8'd0; Rsp_Ready = 1'b0;
      cmd_valid4 = 1'b0; cmd_sel4 = 4'd0; cmd_a4 = 8'd0; cmd_b4 = 8'd0; rsp_ready4 = 1'b0;
      ula_res4 = 16'd0; ula_maior4 = 1'b0; ula_menor4 = 1'b0; ula_igual4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({Cmd_Ready, Rsp_Valid, Num_Ops, Num_Erros, Rsp_Resultado, Ula_A} !== {1'b1, 1'b0, 48'd0}) begin
         fails++; $display("FAIL power_on_reset got rdy=%b vld=%b ops=%0d err=%0d res=%h ua=%h want 1 0 0 0 0 0",
                           Cmd_Ready, Rsp_Valid, Num_Ops, Num_Erros, Rsp_Resultado, Ula_A);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_soma();
      test_div0();
      test_random();
      test_backpressure();
      test_illegal();
      test_capture();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
